// File: rtl/chunked_borrow_subtractor.sv
// chunked_borrow_subtractor
// Multi-cycle wide subtractor: Diff = inA - inB - inBorrow, resolved one
// CHUNK-bit slice per clock (LSB slice first). Each slice uses a
// parallel-prefix borrow network seeded from the registered inter-slice
// borrow, so the per-cycle path is one CHUNK-bit prefix tree plus an XOR.
// Valid/ready handshakes on both sides let the sequencer stall the block.

module chunked_borrow_subtractor #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             inBorrow,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] Diff,
  output logic             BorrowOut,
  output logic             Zero,
  output logic             Overflow
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Kogge-Stone style prefix over borrow generate/propagate pairs.
  // Returns the borrow into every bit [CHUNK-1:0] plus the slice borrow-out
  // in bit CHUNK, all derived from the single slice borrow-in.
  function automatic logic [CHUNK:0] borrow_prefix(
    input logic [CHUNK-1:0] g,
    input logic [CHUNK-1:0] p,
    input logic             cin
  );
    logic [CHUNK-1:0] gl;
    logic [CHUNK-1:0] pl;
    logic [CHUNK-1:0] gn;
    logic [CHUNK-1:0] pn;
    logic [CHUNK:0]   bv;
    gl = g;
    pl = p;
    for (int d = 1; d < CHUNK; d = d * 2) begin
      gn = gl;
      pn = pl;
      for (int i = d; i < CHUNK; i++) begin
        gn[i] = gl[i] | (pl[i] & gl[i-d]);
        pn[i] = pl[i] & pl[i-d];
      end
      gl = gn;
      pl = pn;
    end
    bv[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      bv[i+1] = gl[i] | (pl[i] & cin);
    end
    return bv;
  endfunction

  state_t             state_r;
  state_t             state_next_s;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic               borrow_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   diff_r;
  logic               borrow_out_r;
  logic               zero_r;
  logic               overflow_r;

  logic               accept_s;
  logic               last_slice_s;
  logic [CHUNK-1:0]   a_slice_s;
  logic [CHUNK-1:0]   b_slice_s;
  logic [CHUNK-1:0]   g_s;
  logic [CHUNK-1:0]   p_s;
  logic [CHUNK:0]     bvec_s;
  logic [CHUNK-1:0]   d_slice_s;
  logic [WIDTH-1:0]   diff_next_s;
  logic               in_ready_s;
  logic               out_valid_s;

  assign accept_s     = (state_r == ST_IDLE) && inValid;
  assign last_slice_s = (cnt_r == CNT_W'(N - 1));

  // Slice datapath: select the active slice and resolve its borrows.
  always_comb begin
    a_slice_s   = a_r[int'(cnt_r) * CHUNK +: CHUNK];
    b_slice_s   = b_r[int'(cnt_r) * CHUNK +: CHUNK];
    g_s         = ~a_slice_s & b_slice_s;
    p_s         = ~(a_slice_s ^ b_slice_s);
    bvec_s      = borrow_prefix(g_s, p_s, borrow_r);
    d_slice_s   = a_slice_s ^ b_slice_s ^ bvec_s[CHUNK-1:0];
    diff_next_s = diff_r;
    diff_next_s[int'(cnt_r) * CHUNK +: CHUNK] = d_slice_s;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: IDLE -> RUN on accept, RUN -> DONE after last slice,
  // DONE -> IDLE on consumer handshake.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (inValid) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_slice_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (outReady) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Handshake outputs decoded straight from the state register.
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        in_ready_s  = 1'b1;
        out_valid_s = 1'b0;
      end
      ST_RUN: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
      end
      ST_DONE: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b1;
      end
      default: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // Operand capture at accept, then one slice written per RUN cycle; flags
  // update only on the final slice and hold until the next operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r          <= {WIDTH{1'b0}};
      b_r          <= {WIDTH{1'b0}};
      borrow_r     <= 1'b0;
      cnt_r        <= {CNT_W{1'b0}};
      diff_r       <= {WIDTH{1'b0}};
      borrow_out_r <= 1'b0;
      zero_r       <= 1'b0;
      overflow_r   <= 1'b0;
    end else if (accept_s) begin
      a_r      <= inA;
      b_r      <= inB;
      borrow_r <= inBorrow;
      cnt_r    <= {CNT_W{1'b0}};
    end else if (state_r == ST_RUN) begin
      diff_r   <= diff_next_s;
      borrow_r <= bvec_s[CHUNK];
      cnt_r    <= cnt_r + CNT_W'(1);
      if (last_slice_s) begin
        borrow_out_r <= bvec_s[CHUNK];
        overflow_r   <= bvec_s[CHUNK-1] ^ bvec_s[CHUNK];
        zero_r       <= (diff_next_s == {WIDTH{1'b0}});
      end
    end
  end

  assign inReady   = in_ready_s;
  assign outValid  = out_valid_s;
  assign Diff      = diff_r;
  assign BorrowOut = borrow_out_r;
  assign Zero      = zero_r;
  assign Overflow  = overflow_r;

endmodule

// File: tb/tb_chunked_borrow_subtractor.sv
// Self-checking bench for chunked_borrow_subtractor: directed cases plus
// randomized operations, with a scoreboard fed by the stimulus side and
// drained by an independent output monitor.

module tb_chunked_borrow_subtractor;

  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int N     = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             inValid = 1'b0;
  logic             inReady;
  logic [WIDTH-1:0] inA = '0;
  logic [WIDTH-1:0] inB = '0;
  logic             inBorrow = 1'b0;
  logic             outValid;
  logic             outReady = 1'b1;
  logic [WIDTH-1:0] Diff;
  logic             BorrowOut;
  logic             Zero;
  logic             Overflow;

  chunked_borrow_subtractor #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady),
    .inA(inA), .inB(inB), .inBorrow(inBorrow), .outValid(outValid),
    .outReady(outReady), .Diff(Diff), .BorrowOut(BorrowOut), .Zero(Zero),
    .Overflow(Overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] diff;
    logic             bo;
    logic             z;
    logic             ov;
    int               acc;
  } exp_t;

  exp_t             exp_q[$];
  int               n_chk = 0;
  int               n_fail = 0;
  int               cyc = 0;
  logic [WIDTH-1:0] model_diff = '0;
  logic [WIDTH-1:0] prev_diff = '0;
  logic             rr_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain wide arithmetic on the operands.
  task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic bin, output exp_t e);
    longint ua, ub, ur, sa, sb, sr;
    ua = a; ub = b;
    ur = ua - ub - longint'(bin);
    sa = $signed(a); sb = $signed(b);
    sr = sa - sb - longint'(bin);
    e.diff = ur[WIDTH-1:0];
    e.bo   = (ur < 0);
    e.z    = (e.diff == '0);
    e.ov   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    e.acc  = cyc;
  endtask

  task automatic push_exp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
    exp_t e;
    model(a, b, bin, e);
    prev_diff  = model_diff;
    model_diff = e.diff;
    exp_q.push_back(e);
  endtask

  // Issue one operation; junk on the inputs while the DUT is busy must be ignored.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
    int guard = 0;
    @(posedge clk); #1;
    while (!inReady && guard < 200) begin
      inValid = 1'($urandom); inA = $urandom; inB = $urandom; inBorrow = 1'($urandom);
      @(posedge clk); #1;
      guard++;
    end
    if (!inReady) chk("ready_timeout", 64'(inReady), 64'd1);
    inValid = 1'b1; inA = a; inB = b; inBorrow = bin;
    @(posedge clk); #1;
    chk("accepted", 64'(inReady), 64'd0);
    push_exp(a, b, bin);
    inValid = 1'b0; inA = $urandom; inB = $urandom; inBorrow = 1'($urandom);
  endtask

  task automatic wait_done();
    int guard = 0;
    while ((exp_q.size() != 0 || !inReady) && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 300) chk("done_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: latency on the rising edge of outValid, scoreboard compare on handshake.
  initial begin : monitor
    logic prev_v;
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
      end else begin
        if (outValid && !prev_v) begin
          if (exp_q.size() == 0) chk("unexpected_valid", 64'd1, 64'd0);
          else chk("latency", 64'(cyc - exp_q[0].acc), 64'(N));
        end
        if (outValid && outReady && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("diff", 64'(Diff), 64'(e.diff));
          chk("borrow_out", 64'(BorrowOut), 64'(e.bo));
          chk("zero", 64'(Zero), 64'(e.z));
          chk("overflow", 64'(Overflow), 64'(e.ov));
        end
        prev_v = outValid;
      end
    end
  end

  // Random consumer backpressure during the random phase.
  initial begin : ready_gen
    forever begin
      @(posedge clk); #1;
      if (rr_en) outReady = 1'($urandom);
    end
  end

  initial begin : stim
    exp_t bp;
    int   vcount;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_diff", 64'(Diff), 64'd0);
    chk("rst_flags", {61'd0, BorrowOut, Zero, Overflow}, 64'd0);
    chk("rst_out_valid", 64'(outValid), 64'd0);
    chk("rst_in_ready", 64'(inReady), 64'd1);
    @(negedge clk); rst_n = 1'b1;

    // Reset mid-RUN aborts the operation
    issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_abort_diff", 64'(Diff), 64'({prev_diff[31:16], model_diff[15:0]}));
    rst_n = 1'b0;
    #1;
    chk("abort_diff", 64'(Diff), 64'd0);
    chk("abort_out_valid", 64'(outValid), 64'd0);
    chk("abort_in_ready", 64'(inReady), 64'd1);
    exp_q.delete();
    model_diff = '0;
    @(negedge clk); rst_n = 1'b1;
    vcount = 0;
    repeat (10) begin
      @(negedge clk);
      if (outValid) vcount++;
    end
    chk("abort_no_valid", 64'(vcount), 64'd0);

    // Directed cases
    issue(32'h0000_0000, 32'h0000_0001, 1'b0); wait_done();
    issue(32'h8000_0000, 32'h0000_0001, 1'b0); wait_done();
    issue(32'h1234_5678, 32'h1234_5677, 1'b1); wait_done();

    // Cross-slice partial borrow: one slice per edge
    issue(32'h0001_0000, 32'h0000_0001, 1'b0);
    chk("slice_e0", 64'(Diff), 64'(prev_diff));
    @(posedge clk); #1;
    chk("slice_e1", 64'(Diff), 64'({prev_diff[31:8], model_diff[7:0]}));
    @(posedge clk); #1;
    chk("slice_e2", 64'(Diff), 64'({prev_diff[31:16], model_diff[15:0]}));
    wait_done();

    // Backpressure: stall in DONE while inputs toggle
    outReady = 1'b0;
    issue(32'hDEAD_BEEF, 32'h1357_9BDF, 1'b1);
    bp = exp_q[0];
    vcount = 0;
    while (!outValid && vcount < 20) begin
      @(negedge clk);
      vcount++;
    end
    chk("bp_reach_done", 64'(outValid), 64'd1);
    repeat (5) begin
      @(posedge clk); #1;
      inValid = ~inValid; inA = $urandom; inB = $urandom; inBorrow = 1'($urandom);
      @(negedge clk);
      chk("bp_out_valid", 64'(outValid), 64'd1);
      chk("bp_in_ready", 64'(inReady), 64'd0);
      chk("bp_diff", 64'(Diff), 64'(bp.diff));
      chk("bp_flags", {61'd0, BorrowOut, Zero, Overflow}, {61'd0, bp.bo, bp.z, bp.ov});
    end
    @(posedge clk); #1;
    outReady = 1'b1; inValid = 1'b1; inA = 32'h0000_0005; inB = 32'h0000_0007; inBorrow = 1'b1;
    @(posedge clk); #1;
    chk("bp_ready_after_hs", 64'(inReady), 64'd1);
    chk("bp_valid_after_hs", 64'(outValid), 64'd0);
    @(posedge clk); #1;
    chk("bp_next_accept", 64'(inReady), 64'd0);
    push_exp(32'h0000_0005, 32'h0000_0007, 1'b1);
    inValid = 1'b0;
    wait_done();

    // Randomized operations with random consumer stalls
    rr_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      logic [WIDTH-1:0] ra, rb;
      ra = $urandom;
      rb = (k % 5 == 0) ? ra : $urandom;
      issue(ra, rb, 1'($urandom));
    end
    wait_done();
    rr_en = 1'b0;
    outReady = 1'b1;
    repeat (3) @(posedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
